// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: stage indices,
// FSM encodings, PC constants and small mask helpers.
// Optional feature macro used by this slice: PIPE_CTRL_PERF_EN.
package pipeline_ctrl_pkg;

  localparam int NSTAGE = 5;

  localparam int STAGE_IF  = 0;
  localparam int STAGE_ID  = 1;
  localparam int STAGE_EX  = 2;
  localparam int STAGE_MEM = 3;
  localparam int STAGE_WB  = 4;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_BR_PEND   = 2'd1,
    ST_EXC_DRAIN = 2'd2
  } state_e;

  localparam logic [31:0] PC_ZERO  = 32'h0000_0000;
  localparam logic [31:0] PC_RESET = 32'h0000_0000;

  // Exception squashes every stage register up to and including ex_mem.
  localparam logic [NSTAGE-1:0] EXC_FLUSH = 5'b01111;
  // Branch redirect squashes the two wrong-path instructions (IF, ID).
  localparam logic [NSTAGE-1:0] BR_FLUSH  = 5'b00011;

  // Stage registers 0..idx all hold.
  function automatic logic [NSTAGE-1:0] hold_mask_upto(input logic [1:0] idx);
    hold_mask_upto = (5'b00010 << idx) - 5'b00001;
  endfunction

  // Single bubble inserted just downstream of the stalled stage.
  function automatic logic [NSTAGE-1:0] bubble_mask_after(input logic [1:0] idx);
    bubble_mask_after = 5'b00010 << idx;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline datapath and its stall/flush controller.
// master = controller side, slave = datapath side.
interface pipeline_ctrl_if
  import pipeline_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
);
  logic [NSTAGE-1:0] stallreq_i;
  logic              branch_redirect_i;
  logic [ADDR_W-1:0] branch_target_i;
  logic              excp_i;
  logic [ADDR_W-1:0] excp_vector_i;
  logic [NSTAGE-1:0] stall_o;
  logic [NSTAGE-1:0] flush_o;
  logic              redirect_valid_o;
  logic [ADDR_W-1:0] redirect_pc_o;
  logic [1:0]        state_o;

  modport master (
    input  stallreq_i, branch_redirect_i, branch_target_i, excp_i, excp_vector_i,
    output stall_o, flush_o, redirect_valid_o, redirect_pc_o, state_o
  );

  modport slave (
    output stallreq_i, branch_redirect_i, branch_target_i, excp_i, excp_vector_i,
    input  stall_o, flush_o, redirect_valid_o, redirect_pc_o, state_o
  );
endinterface

// File: rtl/pipeline_ctrl_perf_counter.sv
// Free-running 32-bit event counter (wraps), used for pipeline performance
// statistics when PIPE_CTRL_PERF_EN is defined.
module pipe_perf_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_i,
  output logic [31:0] count_o
);
  logic [31:0] count_q;
  logic [31:0] count_d;

  // Next count: step by one on each qualifying cycle.
  always_comb begin
    count_d = count_q;
    if (inc_i) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 32'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Priority: exception > branch > stall. A branch resolved while EX is frozen
// is parked in BR_PEND until EX can move. After an exception the front end
// gets REFILL_CYCLES quiet cycles to fetch from the vector.
// Defining PIPE_CTRL_PERF_EN adds stall_cycles_o / flush_events_o counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int REFILL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  pipeline_ctrl_if.master bus
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] flush_events_o
`endif
);

  localparam int CNT_W = (REFILL_CYCLES < 2) ? 1 : $clog2(REFILL_CYCLES + 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              have_stall_s;
  logic [1:0]        sstar_s;
  logic              deep_s;
  logic [NSTAGE-1:0] rule_stall_s;
  logic [NSTAGE-1:0] rule_flush_s;

  logic [NSTAGE-1:0] stall_s;
  logic [NSTAGE-1:0] flush_s;
  logic              redir_v_s;
  logic [ADDR_W-1:0] redir_pc_s;

  // Priority encoder: deepest stage (IF..MEM) requesting a hold; WB is ignored.
  always_comb begin
    have_stall_s = 1'b1;
    sstar_s      = 2'd0;
    if (bus.stallreq_i[STAGE_MEM]) begin
      sstar_s = 2'd3;
    end else if (bus.stallreq_i[STAGE_EX]) begin
      sstar_s = 2'd2;
    end else if (bus.stallreq_i[STAGE_ID]) begin
      sstar_s = 2'd1;
    end else if (bus.stallreq_i[STAGE_IF]) begin
      sstar_s = 2'd0;
    end else begin
      have_stall_s = 1'b0;
    end
  end

  // Plain stall rule: hold 0..s*, bubble into s*+1. deep_s means EX is frozen.
  assign rule_stall_s = have_stall_s ? hold_mask_upto(sstar_s)    : 5'b00000;
  assign rule_flush_s = have_stall_s ? bubble_mask_after(sstar_s) : 5'b00000;
  assign deep_s       = have_stall_s & sstar_s[1];

  // FSM next state and 0-cycle control outputs; everything forced quiet under reset.
  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    cnt_d      = cnt_q;
    stall_s    = 5'b00000;
    flush_s    = 5'b00000;
    redir_v_s  = 1'b0;
    redir_pc_s = '0;
    if (rst) begin
      state_d = ST_RUN;
      tgt_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus.excp_i) begin
            flush_s    = EXC_FLUSH;
            redir_v_s  = 1'b1;
            redir_pc_s = bus.excp_vector_i;
            cnt_d      = CNT_W'(REFILL_CYCLES);
            state_d    = ST_EXC_DRAIN;
          end else if (bus.branch_redirect_i && !deep_s) begin
            stall_s    = rule_stall_s;
            flush_s    = rule_flush_s | BR_FLUSH;
            redir_v_s  = 1'b1;
            redir_pc_s = bus.branch_target_i;
          end else if (bus.branch_redirect_i) begin
            stall_s = rule_stall_s;
            flush_s = rule_flush_s;
            tgt_d   = bus.branch_target_i;
            state_d = ST_BR_PEND;
          end else begin
            stall_s = rule_stall_s;
            flush_s = rule_flush_s;
          end
        end
        ST_BR_PEND: begin
          if (bus.excp_i) begin
            flush_s    = EXC_FLUSH;
            redir_v_s  = 1'b1;
            redir_pc_s = bus.excp_vector_i;
            cnt_d      = CNT_W'(REFILL_CYCLES);
            state_d    = ST_EXC_DRAIN;
          end else if (!deep_s) begin
            stall_s    = rule_stall_s;
            flush_s    = rule_flush_s | BR_FLUSH;
            redir_v_s  = 1'b1;
            redir_pc_s = tgt_q;
            state_d    = ST_RUN;
          end else begin
            stall_s = rule_stall_s;
            flush_s = rule_flush_s;
          end
        end
        ST_EXC_DRAIN: begin
          // IF keeps fetching from the vector; an IF-side hold only bubbles ID.
          flush_s[STAGE_ID] = bus.stallreq_i[STAGE_IF];
          cnt_d             = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_EXC_DRAIN;
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
    // Never hold and squash the same register: squash wins.
    stall_s = stall_s & ~flush_s;
  end

  // State, parked branch target and refill counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      tgt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.stall_o          = stall_s;
  assign bus.flush_o          = flush_s;
  assign bus.redirect_valid_o = redir_v_s;
  assign bus.redirect_pc_o    = redir_pc_s;
  assign bus.state_o          = rst ? ST_RUN : state_q;

`ifdef PIPE_CTRL_PERF_EN
  pipe_perf_counter u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (|stall_s),
    .count_o (stall_cycles_o)
  );

  pipe_perf_counter u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (redir_v_s),
    .count_o (flush_events_o)
  );
`endif

endmodule
